// File: rtl/dit_frame_sched.sv
// dit_frame_sched: shares one dit FFT core between NCH sample sources.
// Grants whole N-sample frames round-robin, muxes the granted source onto the
// dit input, queues each frame's channel in a tag FIFO and labels the dit
// output stream with channel number and frame-start marker.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_req/in_data/in_nd            per-channel request, sample bus, valid
//   grant                           one-hot grant of the streaming channel
//   dit_in_data/dit_in_nd           sample and valid towards the dit core
//   dit_out_data/dit_out_nd         dit core result and valid
//   dit_error                       dit core error
//   out_data/out_nd/out_ch/out_first labelled result stream
//   error                           sticky error flag
module dit_frame_sched #(
  parameter int unsigned N      = 16,
  parameter int unsigned NLOG2  = 4,
  parameter int unsigned X_WDTH = 32,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CHLOG2 = 1,
  parameter int unsigned TDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            in_req,
  input  logic [NCH*2*X_WDTH-1:0]   in_data,
  input  logic [NCH-1:0]            in_nd,
  output logic [NCH-1:0]            grant,
  output logic [2*X_WDTH-1:0]       dit_in_data,
  output logic                      dit_in_nd,
  input  logic [2*X_WDTH-1:0]       dit_out_data,
  input  logic                      dit_out_nd,
  input  logic                      dit_error,
  output logic [2*X_WDTH-1:0]       out_data,
  output logic                      out_nd,
  output logic [CHLOG2-1:0]         out_ch,
  output logic                      out_first,
  output logic                      error
);

  localparam int unsigned SW  = 2 * X_WDTH;
  localparam int unsigned TAW = $clog2(TDEPTH);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e              state_q, state_d;
  logic [CHLOG2-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CHLOG2-1:0]   gch_q, gch_d;
  logic [NCH-1:0]      grant_q, grant_d;
  logic [NLOG2-1:0]    in_cnt_q, in_cnt_d;
  logic [SW-1:0]       dit_in_data_q, dit_in_data_d;
  logic                dit_in_nd_q, dit_in_nd_d;
  logic [TAW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [TAW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TAW:0]        tcnt_q, tcnt_d;
  logic [CHLOG2-1:0]   tag_mem_q [TDEPTH];
  logic [SW-1:0]       out_data_q, out_data_d;
  logic                out_nd_q, out_nd_d;
  logic [CHLOG2-1:0]   out_ch_q, out_ch_d;
  logic                out_first_q, out_first_d;
  logic [NLOG2-1:0]    out_cnt_q, out_cnt_d;
  logic                error_q, error_d;

  logic                pick_found;
  logic [CHLOG2-1:0]   pick_ch;
  logic [CHLOG2-1:0]   cand;
  logic [SW-1:0]       sel_data;
  logic                push, pop, fifo_full, fifo_empty;
  logic [CHLOG2-1:0]   tag_head;

  assign fifo_full  = (tcnt_q == (TAW+1)'(TDEPTH));
  assign fifo_empty = (tcnt_q == '0);
  assign tag_head   = tag_mem_q[rd_ptr_q];

  // Round-robin search: first requester at or after rr_ptr, wrapping round.
  always_comb begin : pick_proc
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = CHLOG2'((32'(rr_ptr_q) + i) % NCH);
      if (!pick_found && in_req[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  // Granted channel's sample lane.
  always_comb begin : mux_proc
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gch_q == CHLOG2'(i)) sel_data = in_data[i*SW +: SW];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : next_proc
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gch_d         = gch_q;
    grant_d       = grant_q;
    in_cnt_d      = in_cnt_q;
    dit_in_data_d = dit_in_data_q;
    dit_in_nd_d   = 1'b0;
    push          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          grant_d  = NCH'(1) << pick_ch;
          gch_d    = pick_ch;
          push     = 1'b1;
          rr_ptr_d = CHLOG2'((32'(pick_ch) + 32'd1) % NCH);
          in_cnt_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (in_nd[gch_q]) begin
          dit_in_data_d = sel_data;
          dit_in_nd_d   = 1'b1;
          in_cnt_d      = in_cnt_q + NLOG2'(1);
          // Grant drops on the edge that launches the last sample.
          if (in_cnt_q == NLOG2'(N - 1)) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output labelling; an orphan result reports channel 0.
    out_data_d  = dit_out_data;
    out_nd_d    = dit_out_nd;
    out_ch_d    = fifo_empty ? '0 : tag_head;
    out_first_d = dit_out_nd && (out_cnt_q == '0);
    out_cnt_d   = dit_out_nd ? out_cnt_q + NLOG2'(1) : out_cnt_q;
    pop         = dit_out_nd && (out_cnt_q == NLOG2'(N - 1)) && !fifo_empty;

    wr_ptr_d = push ? wr_ptr_q + TAW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + TAW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   tcnt_d = tcnt_q + (TAW+1)'(1);
      2'b01:   tcnt_d = tcnt_q - (TAW+1)'(1);
      default: tcnt_d = tcnt_q;
    endcase

    error_d = error_q | dit_error | (|(in_nd & ~grant_q)) |
              (dit_out_nd & fifo_empty);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gch_q         <= '0;
      grant_q       <= '0;
      in_cnt_q      <= '0;
      dit_in_data_q <= '0;
      dit_in_nd_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tcnt_q        <= '0;
      out_data_q    <= '0;
      out_nd_q      <= 1'b0;
      out_ch_q      <= '0;
      out_first_q   <= 1'b0;
      out_cnt_q     <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gch_q         <= gch_d;
      grant_q       <= grant_d;
      in_cnt_q      <= in_cnt_d;
      dit_in_data_q <= dit_in_data_d;
      dit_in_nd_q   <= dit_in_nd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tcnt_q        <= tcnt_d;
      out_data_q    <= out_data_d;
      out_nd_q      <= out_nd_d;
      out_ch_q      <= out_ch_d;
      out_first_q   <= out_first_d;
      out_cnt_q     <= out_cnt_d;
      error_q       <= error_d;
    end
  end

  // Tag FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TDEPTH; i++) tag_mem_q[i] <= '0;
    end else if (push) begin
      tag_mem_q[wr_ptr_q] <= pick_ch;
    end
  end

  assign grant       = grant_q;
  assign dit_in_data = dit_in_data_q;
  assign dit_in_nd   = dit_in_nd_q;
  assign out_data    = out_data_q;
  assign out_nd      = out_nd_q;
  assign out_ch      = out_ch_q;
  assign out_first   = out_first_q;
  assign error       = error_q;

endmodule

// File: tb/tb_dit_frame_sched.sv
// Directed bench for dit_frame_sched: arbitration, muxing, tag labelling,
// FIFO-full back-pressure and error/reset behaviour.
module tb_dit_frame_sched;

  localparam int unsigned N      = 16;
  localparam int unsigned NLOG2  = 4;
  localparam int unsigned X_WDTH = 32;
  localparam int unsigned NCH    = 2;
  localparam int unsigned CHLOG2 = 1;
  localparam int unsigned TDEPTH = 4;
  localparam int unsigned SW     = 2 * X_WDTH;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NCH-1:0]          in_req = '0;
  logic [NCH*SW-1:0]       in_data = '0;
  logic [NCH-1:0]          in_nd = '0;
  logic [NCH-1:0]          grant;
  logic [SW-1:0]           dit_in_data;
  logic                    dit_in_nd;
  logic [SW-1:0]           dit_out_data = '0;
  logic                    dit_out_nd = 1'b0;
  logic                    dit_error = 1'b0;
  logic [SW-1:0]           out_data;
  logic                    out_nd;
  logic [CHLOG2-1:0]       out_ch;
  logic                    out_first;
  logic                    error;

  int n_tests = 0;
  int n_fail  = 0;

  dit_frame_sched #(
    .N(N), .NLOG2(NLOG2), .X_WDTH(X_WDTH), .NCH(NCH), .CHLOG2(CHLOG2), .TDEPTH(TDEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req), .in_data(in_data), .in_nd(in_nd),
    .grant(grant), .dit_in_data(dit_in_data), .dit_in_nd(dit_in_nd),
    .dit_out_data(dit_out_data), .dit_out_nd(dit_out_nd), .dit_error(dit_error),
    .out_data(out_data), .out_nd(out_nd), .out_ch(out_ch),
    .out_first(out_first), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int ch, input logic [63:0] v);
    in_data[ch*SW +: SW] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_req = '0; in_nd = '0; in_data = '0;
    dit_out_nd = 1'b0; dit_out_data = '0; dit_error = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  // Streams one whole frame on an already granted channel.
  task automatic send_frame(input int ch, input logic [63:0] base);
    logic [NCH-1:0] g;
    g = NCH'(1) << ch;
    for (int s = 0; s < 16; s++) begin
      in_nd = g;
      set_lane(ch, base + 64'(s));
      step();
      chk("fr_nd", 64'(dit_in_nd), 64'd1);
      chk("fr_data", dit_in_data, base + 64'(s));
      chk("fr_grant", 64'(grant), (s == 15) ? 64'd0 : 64'(g));
    end
    in_nd = '0;
  endtask

  initial begin
    // Test 1: single channel frame.
    do_reset();
    chk("t1_out_nd0", 64'(out_nd), 64'd0);
    in_req = 2'b01;
    step();
    chk("t1_grant", 64'(grant), 64'd1);
    chk("t1_nd_idle", 64'(dit_in_nd), 64'd0);
    in_req = '0;
    send_frame(0, 64'd0);
    step();
    chk("t1_nd_after", 64'(dit_in_nd), 64'd0);
    chk("t1_error", 64'(error), 64'd0);

    // Test 2: round-robin, both requesting from reset.
    do_reset();
    in_req = 2'b11;
    step();
    chk("t2_g0", 64'(grant), 64'd1);
    send_frame(0, 64'h10);
    step();
    chk("t2_idle_nd", 64'(dit_in_nd), 64'd0);
    chk("t2_g1", 64'(grant), 64'd2);
    set_lane(0, 64'hdead_beef);
    send_frame(1, 64'h100);
    step();
    chk("t2_g0_again", 64'(grant), 64'd1);
    chk("t2_error", 64'(error), 64'd0);
    in_req = '0;

    // Test 3: labelled output for frames ch1 then ch0, then orphan result.
    do_reset();
    in_req = 2'b10;
    step();
    chk("t3_g1", 64'(grant), 64'd2);
    in_req = 2'b01;
    send_frame(1, 64'h200);
    step();
    chk("t3_g0", 64'(grant), 64'd1);
    in_req = '0;
    send_frame(0, 64'h300);
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 16; j++) begin
        dit_out_nd = 1'b1;
        dit_out_data = 64'(f * 1000 + j);
        step();
        chk("t3_out_nd", 64'(out_nd), 64'd1);
        chk("t3_out_data", out_data, 64'(f * 1000 + j));
        chk("t3_out_ch", 64'(out_ch), (f == 0) ? 64'd1 : 64'd0);
        chk("t3_out_first", 64'(out_first), (j == 0) ? 64'd1 : 64'd0);
      end
    end
    dit_out_nd = 1'b0;
    step();
    chk("t3_out_nd_off", 64'(out_nd), 64'd0);
    chk("t3_error_clean", 64'(error), 64'd0);
    dit_out_nd = 1'b1;
    dit_out_data = 64'd77;
    step();
    dit_out_nd = 1'b0;
    chk("t3_orph_nd", 64'(out_nd), 64'd1);
    chk("t3_orph_ch", 64'(out_ch), 64'd0);
    chk("t3_orph_first", 64'(out_first), 64'd1);
    chk("t3_orph_err", 64'(error), 64'd1);
    step();
    chk("t3_orph_sticky", 64'(error), 64'd1);

    // Test 4: tag FIFO full blocks the 5th grant until one frame drains.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      in_req = 2'b01;
      step();
      chk("t4_grant", 64'(grant), 64'd1);
      in_req = '0;
      send_frame(0, 64'(f * 16));
    end
    in_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_full_nogrant", 64'(grant), 64'd0);
    end
    for (int j = 0; j < 16; j++) begin
      dit_out_nd = 1'b1;
      dit_out_data = 64'(j);
      step();
      chk("t4_drain_nogrant", 64'(grant), 64'd0);
      chk("t4_drain_first", 64'(out_first), (j == 0) ? 64'd1 : 64'd0);
    end
    dit_out_nd = 1'b0;
    step();
    chk("t4_grant_after", 64'(grant), 64'd1);
    chk("t4_error", 64'(error), 64'd0);
    in_req = '0;

    // Test 5: non-granted in_nd sets sticky error; reset clears it.
    do_reset();
    in_req = 2'b01;
    step();
    in_req = '0;
    for (int s = 0; s < 3; s++) begin
      in_nd = 2'b01;
      set_lane(0, 64'(s));
      step();
    end
    in_nd = 2'b10;
    set_lane(1, 64'hbad);
    step();
    in_nd = '0;
    chk("t5_dropped", 64'(dit_in_nd), 64'd0);
    chk("t5_err", 64'(error), 64'd1);
    step();
    step();
    chk("t5_err_sticky", 64'(error), 64'd1);
    chk("t5_grant_held", 64'(grant), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_err", 64'(error), 64'd0);
    chk("t5_rst_grant", 64'(grant), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Test 6: mid-frame async reset, then dit_error.
    do_reset();
    in_req = 2'b01;
    step();
    in_req = '0;
    in_nd = 2'b01;
    set_lane(0, 64'd42);
    dit_out_nd = 1'b1;
    dit_out_data = 64'd5;
    step();
    chk("t6_in_nd", 64'(dit_in_nd), 64'd1);
    chk("t6_in_data", dit_in_data, 64'd42);
    chk("t6_out_nd", 64'(out_nd), 64'd1);
    chk("t6_out_ch", 64'(out_ch), 64'd0);
    chk("t6_no_orphan", 64'(error), 64'd0);
    in_nd = '0;
    dit_out_nd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_in_nd", 64'(dit_in_nd), 64'd0);
    chk("t6_rst_out_nd", 64'(out_nd), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    dit_error = 1'b1;
    step();
    dit_error = 1'b0;
    step();
    chk("t6_dit_error", 64'(error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
